// File: rtl/fp32_sub_unit.sv
// Registered binary32 subtractor (result = a - b), round-to-nearest-even, DAZ/FTZ.
// One cycle latency, one operation per cycle, no backpressure.
module fp32_sub_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        out_valid
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) begin
      n = v[i] ? 5'(26 - i) : n;
    end
    return n;
  endfunction

  logic [7:0]  ea_s, eb_s, e_big_s, e_small_s, d_s;
  logic [22:0] fa_s, fb_s;
  logic        sa_s, sb_s, s_big_s, eff_sub_s, swap_s;
  logic        a_nan_s, b_nan_s, a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  logic [23:0] siga_s, sigb_s, sig_big_s, sig_small_s;
  logic [4:0]  d_c_s, lz_s;
  logic [53:0] wide_s;
  logic [26:0] small_al_s, m_s;
  logic [27:0] big_ext_s, small_ext_s, sum_s;
  logic signed [9:0] exp_n_s, exp_r_s;
  logic        rnd_up_s;
  logic [24:0] mant25_s;
  logic [22:0] frac_s;
  logic [31:0] res_s;
  logic [31:0] result_r;
  logic        out_valid_r;

  // Unpack operands, apply DAZ, negate b and order by magnitude.
  always_comb begin
    ea_s     = a[30:23];
    eb_s     = b[30:23];
    fa_s     = a[22:0];
    fb_s     = b[22:0];
    sa_s     = a[31];
    sb_s     = ~b[31];
    a_nan_s  = (ea_s == 8'hFF) && (fa_s != 23'd0);
    b_nan_s  = (eb_s == 8'hFF) && (fb_s != 23'd0);
    a_inf_s  = (ea_s == 8'hFF) && (fa_s == 23'd0);
    b_inf_s  = (eb_s == 8'hFF) && (fb_s == 23'd0);
    a_zero_s = (ea_s == 8'd0);
    b_zero_s = (eb_s == 8'd0);
    siga_s   = a_zero_s ? 24'd0 : {1'b1, fa_s};
    sigb_s   = b_zero_s ? 24'd0 : {1'b1, fb_s};
    swap_s   = (a[30:0] < b[30:0]);
    eff_sub_s = sa_s ^ sb_s;
    if (swap_s) begin
      e_big_s     = eb_s;
      e_small_s   = ea_s;
      sig_big_s   = sigb_s;
      sig_small_s = siga_s;
      s_big_s     = sb_s;
    end else begin
      e_big_s     = ea_s;
      e_small_s   = eb_s;
      sig_big_s   = siga_s;
      sig_small_s = sigb_s;
      s_big_s     = sa_s;
    end
  end

  // Align the smaller significand with guard/round/sticky, then add or subtract.
  always_comb begin
    d_s         = e_big_s - e_small_s;
    d_c_s       = (d_s > 8'd27) ? 5'd27 : d_s[4:0];
    wide_s      = {sig_small_s, 3'b000, 27'd0} >> d_c_s;
    small_al_s  = {wide_s[53:28], wide_s[27] | (|wide_s[26:0])};
    big_ext_s   = {1'b0, sig_big_s, 3'b000};
    small_ext_s = {1'b0, small_al_s};
    if (eff_sub_s) begin
      sum_s = big_ext_s - small_ext_s;
    end else begin
      sum_s = big_ext_s + small_ext_s;
    end
  end

  // Normalize and round to nearest even; a mantissa carry bumps the exponent.
  always_comb begin
    lz_s = lzc27(sum_s[26:0]);
    if (sum_s[27]) begin
      m_s     = {sum_s[27:2], sum_s[1] | sum_s[0]};
      exp_n_s = $signed({2'b00, e_big_s}) + 10'sd1;
    end else begin
      m_s     = sum_s[26:0] << lz_s;
      exp_n_s = $signed({2'b00, e_big_s}) - $signed({5'b00000, lz_s});
    end
    rnd_up_s = m_s[2] & (m_s[1] | m_s[0] | m_s[3]);
    mant25_s = {1'b0, m_s[26:3]} + {24'd0, rnd_up_s};
    if (mant25_s[24]) begin
      frac_s  = mant25_s[23:1];
      exp_r_s = exp_n_s + 10'sd1;
    end else begin
      frac_s  = mant25_s[22:0];
      exp_r_s = exp_n_s;
    end
  end

  // Special values take priority over the arithmetic path.
  always_comb begin
    if (a_nan_s || b_nan_s) begin
      res_s = QNAN;
    end else if (a_inf_s && b_inf_s) begin
      res_s = (sa_s == sb_s) ? {sa_s, 8'hFF, 23'd0} : QNAN;
    end else if (a_inf_s) begin
      res_s = {sa_s, 8'hFF, 23'd0};
    end else if (b_inf_s) begin
      res_s = {sb_s, 8'hFF, 23'd0};
    end else if (a_zero_s && b_zero_s) begin
      // only (-0) - (+0) keeps a negative sign
      res_s = {sa_s & sb_s, 31'd0};
    end else if (sum_s == 28'd0) begin
      res_s = 32'h0000_0000;
    end else if (exp_r_s >= 10'sd255) begin
      res_s = {s_big_s, 8'hFF, 23'd0};
    end else if (exp_r_s <= 10'sd0) begin
      res_s = {s_big_s, 31'd0};
    end else begin
      res_s = {s_big_s, exp_r_s[7:0], frac_s};
    end
  end

  // Output register: reset wins, idle cycles hold the previous result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_r    <= 32'h0000_0000;
      out_valid_r <= 1'b0;
    end else if (in_valid) begin
      result_r    <= res_s;
      out_valid_r <= 1'b1;
    end else begin
      result_r    <= result_r;
      out_valid_r <= 1'b0;
    end
  end

  assign result    = result_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_fp32_sub_unit.sv
// Scoreboard bench for fp32_sub_unit: expected results queued at drive time,
// compared one cycle later; idle cycles check the hold behaviour.
module tb_fp32_sub_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] result;
  logic        out_valid;

  typedef struct {
    logic [31:0] exp;
    string       tag;
  } sb_entry_t;

  sb_entry_t   sb_q[$];
  int          n_pass;
  int          n_total;
  logic        exp_v_r;
  logic        in_rst_r;
  logic [31:0] last_r;
  sb_entry_t   ent;

  fp32_sub_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .result    (result),
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_v_r  = rst_n && in_valid;
    in_rst_r = !rst_n;
    #1;
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, exp_v_r});
    if (in_rst_r) begin
      check_eq("reset_result", result, 32'h0000_0000);
      last_r = 32'h0000_0000;
    end else if (exp_v_r) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_underflow", 32'd1, 32'd0);
      end else begin
        ent = sb_q.pop_front();
        check_eq(ent.tag, result, ent.exp);
        last_r = ent.exp;
      end
    end else begin
      check_eq("hold", result, last_r);
    end
  end

  task automatic op(input logic [31:0] av, input logic [31:0] bv,
                    input logic [31:0] ev, input string tag);
    sb_entry_t e;
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    e.exp    = ev;
    e.tag    = tag;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    last_r   = 32'h0000_0000;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 32'h3F80_0000;
    b        = 32'h4000_0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(32'h40B0_0000, 32'h4010_0000, 32'h4050_0000, "5.5-2.25");
    op(32'h4120_0000, 32'h4040_0000, 32'h40E0_0000, "10-3");
    op(32'h4080_0000, 32'h40C0_0000, 32'hC000_0000, "4-6");
    op(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, "x-x");
    op(32'h8000_0000, 32'h0000_0000, 32'h8000_0000, "-0-+0");
    op(32'h0000_0000, 32'h8000_0000, 32'h0000_0000, "+0--0");
    op(32'h0040_0000, 32'h0000_0000, 32'h0000_0000, "daz");
    op(32'h3F80_0000, 32'h3380_0000, 32'h3F7F_FFFF, "1-ulp");
    op(32'h3F80_0000, 32'hB380_0000, 32'h3F80_0000, "tie_even");
    op(32'h3F80_0000, 32'hB380_0001, 32'h3F80_0001, "round_up");
    op(32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, "overflow");
    op(32'h0080_0001, 32'h0080_0000, 32'h0000_0000, "ftz");
    op(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, "inf-inf");
    op(32'h3F80_0000, 32'hFF80_0000, 32'h7F80_0000, "fin-ninf");
    op(32'h7FA0_0000, 32'h3F80_0000, 32'h7FC0_0000, "nan");
    op(32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, "ninf-fin");
    op(32'h7F80_0000, 32'hFF80_0000, 32'h7F80_0000, "inf-ninf");
    op(32'h3F80_0000, 32'h3F00_0000, 32'h3F00_0000, "1-0.5");

    in_valid = 1'b0;
    a        = 32'h4000_0000;
    b        = 32'h3F80_0000;
    repeat (3) @(negedge clk);

    op(32'h3FC0_0000, 32'hBF00_0000, 32'h4000_0000, "1.5+0.5");
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    check_eq("sb_drain", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
